// File: rtl/snes_controller_reader.sv
// rtl/snes_controller_reader.sv - SNES pad poller: latch/clock/data initiator with registered active-low buttons.
// Optional two-frame match filter on published buttons: define SNES_DEBOUNCE_EN.
module snes_controller_reader #(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Snes_data,
  output logic        Snes_latch,
  output logic        Snes_clk,
  output logic        Up,
  output logic        Down,
  output logic        Left,
  output logic        Right,
  output logic [11:0] Buttons_n,
  output logic        Valid
);

  localparam int PW = $clog2(2 * HALF_CYC);
  localparam int TW = $clog2(POLL_CYC);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(2 * HALF_CYC - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_CYC - 1);
  localparam logic [TW-1:0] POLL_LOAD  = TW'(POLL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase, phase_next;
  logic [3:0]    bit_idx, bit_next;
  logic [TW-1:0] timer;
  logic [15:0]   shreg;
  logic [1:0]    rst_pipe;
  logic [1:0]    data_sync;
  logic          rst_n;
  logic          start;
  logic          sample;
  logic          publish;
  logic          load;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // Pad data is asynchronous to Clk; it is stable for a whole half-period before sampling.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) data_sync <= 2'b11;
    else        data_sync <= {data_sync[0], Snes_data};
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)            timer <= '0;
    else if (timer == '0)  timer <= POLL_LOAD;
    else                   timer <= timer - 1'b1;
  end
  assign start = (timer == '0);

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_idx <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_idx;
    sample     = 1'b0;
    publish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LATCH;
          phase_next = LATCH_LOAD;
        end
      end
      S_LATCH: begin
        if (phase == '0) begin
          state_next = S_SHIFT_LO;
          phase_next = HALF_LOAD;
          bit_next   = '0;
        end else begin
          phase_next = phase - 1'b1;
        end
      end
      S_SHIFT_LO: begin
        if (phase == '0) begin
          sample     = 1'b1;
          state_next = S_SHIFT_HI;
          phase_next = HALF_LOAD;
        end else begin
          phase_next = phase - 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (phase == '0) begin
          if (bit_idx == 4'd15) begin
            state_next = S_DONE;
          end else begin
            bit_next   = bit_idx + 4'd1;
            state_next = S_SHIFT_LO;
            phase_next = HALF_LOAD;
          end
        end else begin
          phase_next = phase - 1'b1;
        end
      end
      S_DONE: begin
        publish    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pad pins are registered from the next state so they stay glitch-free and track the FSM.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      Snes_latch <= 1'b0;
      Snes_clk   <= 1'b1;
    end else begin
      Snes_latch <= (state_next == S_LATCH);
      Snes_clk   <= (state_next != S_SHIFT_LO);
    end
  end

  // Bits arrive LSB first, so after 16 right shifts bit 0 (B) lands in shreg[0].
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)      shreg <= 16'hFFFF;
    else if (sample) shreg <= {data_sync[1], shreg[15:1]};
  end

`ifdef SNES_DEBOUNCE_EN
  logic [11:0] prev;
  logic        match;

  assign match = (shreg[11:0] == prev);
  assign load  = publish && match;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)                prev <= 12'hFFF;
    else if (publish && !match) prev <= shreg[11:0];
  end
`else
  assign load = publish;
`endif

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      Buttons_n <= 12'hFFF;
      Valid     <= 1'b0;
    end else begin
      Valid <= load;
      if (load) Buttons_n <= shreg[11:0];
    end
  end

  assign Up    = Buttons_n[4];
  assign Down  = Buttons_n[5];
  assign Left  = Buttons_n[6];
  assign Right = Buttons_n[7];

endmodule
